// File: rtl/rf_mac_sequencer.sv
// Purpose: borrows the register-file ports from the core and computes sum(A[i]*B[i]) into MAC_REG.
// Latency: len+3 cycles from start to done with grant held high; len==0 completes in 1 cycle.
// Backpressure: rf_gnt low stalls REQ and RUN in place; the WRITE beat commits regardless of grant.
module rf_mac_sequencer #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int MAC_REG = 17
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   input  logic [ADDR_W-1:0] len,
   input  logic              acc_mode,
   input  logic [DATA_W-1:0] mac_in,
   output logic              busy,
   output logic              done,
   output logic              rf_req,
   input  logic              rf_gnt,
   output logic [ADDR_W-1:0] Read_Reg1,
   output logic [ADDR_W-1:0] Read_Reg2,
   input  logic [DATA_W-1:0] Read_Data1,
   input  logic [DATA_W-1:0] Read_Data2,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] Write_Reg,
   output logic [DATA_W-1:0] writeData
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_RUN   = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] acc, acc_nxt;
   logic [ADDR_W-1:0] idx, idx_nxt;
   logic [ADDR_W-1:0] a_q, a_nxt;
   logic [ADDR_W-1:0] b_q, b_nxt;
   logic [ADDR_W-1:0] len_q, len_nxt;
   logic              mode_q, mode_nxt;
   logic [DATA_W-1:0] prod;

   // Only the low DATA_W bits of the product are kept; overflow wraps silently.
   assign prod      = Read_Data1 * Read_Data2;
   assign Write_Reg = ADDR_W'(MAC_REG);

   // State and operand registers; reset clears everything so no write can follow.
   always_ff @(posedge clock) begin
      if (rst) begin
         state  <= S_IDLE;
         acc    <= '0;
         idx    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         len_q  <= '0;
         mode_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         acc    <= acc_nxt;
         idx    <= idx_nxt;
         a_q    <= a_nxt;
         b_q    <= b_nxt;
         len_q  <= len_nxt;
         mode_q <= mode_nxt;
      end
   end

   // Next-state, datapath updates and port control for the borrowed register-file ports.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      idx_nxt   = idx;
      a_nxt     = a_q;
      b_nxt     = b_q;
      len_nxt   = len_q;
      mode_nxt  = mode_q;
      busy      = 1'b0;
      done      = 1'b0;
      rf_req    = 1'b0;
      Read_Reg1 = '0;
      Read_Reg2 = '0;
      RegWrite  = 1'b0;
      writeData = '0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (len != '0) begin
                  a_nxt     = src_a;
                  b_nxt     = src_b;
                  len_nxt   = len;
                  mode_nxt  = acc_mode;
                  idx_nxt   = '0;
                  state_nxt = S_REQ;
               end else begin
                  // Empty vector: report completion without touching the ports.
                  state_nxt = S_DONE;
               end
            end
         end
         S_REQ: begin
            busy   = 1'b1;
            rf_req = 1'b1;
            if (rf_gnt) begin
               acc_nxt   = mode_q ? mac_in : '0;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy      = 1'b1;
            rf_req    = 1'b1;
            // Index arithmetic is ADDR_W wide, so addresses wrap 31 -> 0.
            Read_Reg1 = a_q + idx;
            Read_Reg2 = b_q + idx;
            if (rf_gnt) begin
               acc_nxt = acc + prod;
               idx_nxt = idx + 1'b1;
               if (idx == len_q - 1'b1) begin
                  state_nxt = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            busy      = 1'b1;
            rf_req    = 1'b1;
            // A reset arriving in this cycle must suppress the commit.
            RegWrite  = ~rst;
            writeData = rst ? '0 : acc;
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rf_mac_sequencer.sv
// Bench for rf_mac_sequencer: register-file model, directed vector table, corner sequences, random runs.
// Cycle k is counted from the edge that samples start; outputs are sampled on the falling edge.
// rf_gnt is driven per cycle from a bit mask so stalls can be placed anywhere.
module tb_rf_mac_sequencer;

   logic        clock;
   logic        rst;
   logic        start;
   logic [4:0]  src_a, src_b, len;
   logic        acc_mode;
   logic [31:0] mac_in;
   logic        busy, done, rf_req, rf_gnt;
   logic [4:0]  Read_Reg1, Read_Reg2, Write_Reg;
   logic [31:0] Read_Data1, Read_Data2, writeData;
   logic        RegWrite;

   logic [31:0] rf [32];
   logic [4:0]  rr1_log [128];
   logic [4:0]  rr2_log [128];
   logic        req_log [128];

   int checks   = 0;
   int failures = 0;

   rf_mac_sequencer #(.DATA_W(32), .ADDR_W(5), .MAC_REG(17)) dut (
      .clock(clock), .rst(rst), .start(start), .src_a(src_a), .src_b(src_b),
      .len(len), .acc_mode(acc_mode), .mac_in(mac_in), .busy(busy), .done(done),
      .rf_req(rf_req), .rf_gnt(rf_gnt), .Read_Reg1(Read_Reg1), .Read_Reg2(Read_Reg2),
      .Read_Data1(Read_Data1), .Read_Data2(Read_Data2), .RegWrite(RegWrite),
      .Write_Reg(Write_Reg), .writeData(writeData)
   );

   assign Read_Data1 = rf[Read_Reg1];
   assign Read_Data2 = rf[Read_Reg2];
   assign mac_in     = rf[17];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},      {31'd0, busy},      32'd0);
      check({tag, "_done"},      {31'd0, done},      32'd0);
      check({tag, "_rf_req"},    {31'd0, rf_req},    32'd0);
      check({tag, "_regwrite"},  {31'd0, RegWrite},  32'd0);
      check({tag, "_writedata"}, writeData,          32'd0);
      check({tag, "_rr1"},       {27'd0, Read_Reg1}, 32'd0);
      check({tag, "_rr2"},       {27'd0, Read_Reg2}, 32'd0);
      check({tag, "_write_reg"}, {27'd0, Write_Reg}, 32'd17);
   endtask

   // Reference: dot product over wrapped register indices, 32-bit modular arithmetic.
   function automatic logic [31:0] model_result(input logic [4:0] a, input logic [4:0] b,
                                                input logic [4:0] l, input logic m,
                                                input logic [31:0] init);
      logic [31:0] sum;
      logic [31:0] p;
      logic [4:0]  ia, ib;
      sum = m ? init : 32'd0;
      for (int k = 0; k < int'(l); k++) begin
         ia  = a + 5'(k);
         ib  = b + 5'(k);
         p   = rf[ia] * rf[ib];
         sum = sum + p;
      end
      return sum;
   endfunction

   // Reference timing: one granted REQ cycle, len granted RUN cycles, one WRITE cycle, then done.
   function automatic int model_done(input logic [4:0] l, input logic [127:0] gmask);
      int c;
      int beats;
      if (l == 5'd0) return 1;
      c = 1;
      while (c < 120 && !gmask[c[6:0]]) c++;
      c++;
      beats = 0;
      while (c < 120 && beats < int'(l)) begin
         if (gmask[c[6:0]]) beats++;
         c++;
      end
      return c + 1;
   endfunction

   task automatic run_op(input logic [4:0] a, input logic [4:0] b, input logic [4:0] l,
                         input logic m, input logic [127:0] gmask,
                         input int xstart_cyc, input int rst_cyc, input int max_cyc,
                         output int wr_cyc, output int wr_cnt,
                         output logic [31:0] wr_data, output int done_cyc);
      @(negedge clock);
      start    = 1'b1;
      src_a    = a;
      src_b    = b;
      len      = l;
      acc_mode = m;
      rf_gnt   = gmask[0];
      wr_cyc   = -1;
      wr_cnt   = 0;
      wr_data  = 32'd0;
      done_cyc = -1;
      for (int k = 1; k <= max_cyc; k++) begin
         @(negedge clock);
         start = (k == xstart_cyc);
         if (k == xstart_cyc) begin
            src_a = a + 5'd3;
            len   = 5'd1;
         end
         rf_gnt        = gmask[k[6:0]];
         rr1_log[k[6:0]] = Read_Reg1;
         rr2_log[k[6:0]] = Read_Reg2;
         req_log[k[6:0]] = rf_req;
         check("write_reg_const", {27'd0, Write_Reg}, 32'd17);
         if (RegWrite) begin
            wr_cnt++;
            wr_cyc  = k;
            wr_data = writeData;
            rf[Write_Reg] = writeData;
         end
         if (rst_cyc > 0 && k == rst_cyc + 1) begin
            check_reset_vals("after_mid_rst");
            rst = 1'b0;
         end
         if (rst_cyc > 0 && k == rst_cyc) rst = 1'b1;
         if (done) begin
            done_cyc = k;
            break;
         end
      end
      start  = 1'b0;
      rf_gnt = 1'b1;
   endtask

   typedef struct {
      logic [4:0]  a, b, l;
      logic        m;
      logic [31:0] pre17;
      logic [31:0] exp_r17;
      int          exp_wr_cnt;
      int          exp_wr_cyc;
      int          exp_done;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int          wr_cyc, wr_cnt, done_cyc, exp_done;
      logic [31:0] wr_data, exp_res;
      logic [127:0] all1, gmask;
      logic [4:0]  ra, rb, rl;
      logic        rm;

      all1 = '1;
      vecs[0] = '{a:5'd1,  b:5'd8, l:5'd4, m:1'b0, pre17:32'd55,  exp_r17:32'd70,  exp_wr_cnt:1, exp_wr_cyc:6,  exp_done:7};
      vecs[1] = '{a:5'd1,  b:5'd8, l:5'd4, m:1'b1, pre17:32'd100, exp_r17:32'd170, exp_wr_cnt:1, exp_wr_cyc:6,  exp_done:7};
      vecs[2] = '{a:5'd1,  b:5'd8, l:5'd0, m:1'b1, pre17:32'd170, exp_r17:32'd170, exp_wr_cnt:0, exp_wr_cyc:-1, exp_done:1};
      vecs[3] = '{a:5'd30, b:5'd5, l:5'd3, m:1'b0, pre17:32'd9,   exp_r17:32'd3,   exp_wr_cnt:1, exp_wr_cyc:5,  exp_done:6};

      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      rf[1] = 32'd1;  rf[2] = 32'd2;  rf[3] = 32'd3;  rf[4] = 32'd4;
      rf[8] = 32'd5;  rf[9] = 32'd6;  rf[10] = 32'd7; rf[11] = 32'd8;
      rf[30] = 32'hFFFF_FFFF; rf[31] = 32'd2; rf[0] = 32'd0;
      rf[5] = 32'd3;  rf[6] = 32'd3;  rf[7] = 32'd3;

      // Reset with a simultaneous start: reset must win.
      rst = 1'b1; start = 1'b1; src_a = 5'd1; src_b = 5'd8; len = 5'd4;
      acc_mode = 1'b0; rf_gnt = 1'b1;
      repeat (3) @(negedge clock);
      check_reset_vals("reset");
      rst = 1'b0; start = 1'b0;
      @(negedge clock);
      check("idle_after_rst_busy", {31'd0, busy}, 32'd0);

      // Directed vector table.
      for (int v = 0; v < 4; v++) begin
         rf[17] = vecs[v].pre17;
         run_op(vecs[v].a, vecs[v].b, vecs[v].l, vecs[v].m, all1, 0, 0, 60,
                wr_cyc, wr_cnt, wr_data, done_cyc);
         check($sformatf("vec%0d_wr_cnt", v),   wr_cnt,   vecs[v].exp_wr_cnt);
         check($sformatf("vec%0d_done_cyc", v), done_cyc, vecs[v].exp_done);
         check($sformatf("vec%0d_wr_cyc", v),   wr_cyc,   vecs[v].exp_wr_cyc);
         check($sformatf("vec%0d_r17", v),      rf[17],   vecs[v].exp_r17);
         if (vecs[v].exp_wr_cnt != 0)
            check($sformatf("vec%0d_wr_data", v), wr_data, vecs[v].exp_r17);
      end

      // Wrapped address sequence and address idle values.
      rf[17] = 32'd0;
      run_op(5'd30, 5'd5, 5'd3, 1'b0, all1, 0, 0, 60, wr_cyc, wr_cnt, wr_data, done_cyc);
      check("wrap_rr1_req",   {27'd0, rr1_log[1]}, 32'd0);
      check("wrap_rr1_c2",    {27'd0, rr1_log[2]}, 32'd30);
      check("wrap_rr1_c3",    {27'd0, rr1_log[3]}, 32'd31);
      check("wrap_rr1_c4",    {27'd0, rr1_log[4]}, 32'd0);
      check("wrap_rr2_c4",    {27'd0, rr2_log[4]}, 32'd7);
      check("wrap_rr1_write", {27'd0, rr1_log[5]}, 32'd0);
      check("wrap_result",    wr_data, 32'd3);

      // Grant low for 3 REQ cycles, then dropped for 2 cycles in the second RUN beat.
      gmask = all1;
      gmask[1] = 1'b0; gmask[2] = 1'b0; gmask[3] = 1'b0;
      gmask[6] = 1'b0; gmask[7] = 1'b0;
      run_op(5'd1, 5'd8, 5'd4, 1'b0, gmask, 0, 0, 60, wr_cyc, wr_cnt, wr_data, done_cyc);
      check("gnt_result",   wr_data,  32'd70);
      check("gnt_done_cyc", done_cyc, 32'd12);
      check("gnt_wr_cyc",   wr_cyc,   32'd11);
      for (int k = 1; k <= 11; k++)
         check($sformatf("gnt_req_c%0d", k), {31'd0, req_log[k]}, 32'd1);
      for (int k = 6; k <= 8; k++) begin
         check($sformatf("gnt_rr1_hold_c%0d", k), {27'd0, rr1_log[k]}, 32'd2);
         check($sformatf("gnt_rr2_hold_c%0d", k), {27'd0, rr2_log[k]}, 32'd9);
      end

      // Start during RUN must be ignored.
      run_op(5'd1, 5'd8, 5'd4, 1'b0, all1, 3, 0, 60, wr_cyc, wr_cnt, wr_data, done_cyc);
      check("busy_start_result", wr_data,  32'd70);
      check("busy_start_done",   done_cyc, 32'd7);
      check("busy_start_wr_cnt", wr_cnt,   32'd1);

      // Reset in the third RUN cycle: no write, r17 untouched, then a clean rerun.
      rf[17] = 32'd123;
      run_op(5'd1, 5'd8, 5'd4, 1'b0, all1, 0, 4, 12, wr_cyc, wr_cnt, wr_data, done_cyc);
      check("rst_mid_wr_cnt", wr_cnt,   32'd0);
      check("rst_mid_done",   done_cyc, 32'hFFFF_FFFF);
      check("rst_mid_r17",    rf[17],   32'd123);
      run_op(5'd1, 5'd8, 5'd4, 1'b0, all1, 0, 0, 60, wr_cyc, wr_cnt, wr_data, done_cyc);
      check("post_rst_result", wr_data,  32'd70);
      check("post_rst_done",   done_cyc, 32'd7);

      // Randomized operands, register contents and grant patterns.
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < 32; i++) rf[i] = $urandom;
         ra = 5'($urandom_range(0, 31));
         rb = 5'($urandom_range(0, 31));
         rl = 5'($urandom_range(0, 31));
         rm = 1'($urandom_range(0, 1));
         for (int j = 0; j < 128; j++) gmask[j] = ($urandom_range(0, 3) != 0);
         for (int j = 100; j < 128; j++) gmask[j] = 1'b1;
         exp_res  = model_result(ra, rb, rl, rm, rf[17]);
         exp_done = model_done(rl, gmask);
         run_op(ra, rb, rl, rm, gmask, 0, 0, 120, wr_cyc, wr_cnt, wr_data, done_cyc);
         check($sformatf("rnd%0d_done", t),   done_cyc, exp_done);
         check($sformatf("rnd%0d_wr_cnt", t), wr_cnt, (rl != 5'd0) ? 32'd1 : 32'd0);
         if (rl != 5'd0) begin
            check($sformatf("rnd%0d_result", t), wr_data, exp_res);
            check($sformatf("rnd%0d_wr_cyc", t), wr_cyc,  exp_done - 1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
